// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with 2-flop input sync and mid-bit sampling.
// Latency: byte appears on data/valid about 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT clk after the start edge.
// Backpressure: one-deep output register; a byte completing while it is still full is dropped and flagged by overrun.
module uart_rx #(
  parameter int CLKS_PER_BIT = 104,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       busy,
  output logic       framing_err,
  output logic       overrun
);

  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [2:0]       idx, idx_d;
  logic [7:0]       shift, shift_d;
  logic             sync1, rx_s;
  logic             byte_done, frame_bad;

  // Two-flop resynchroniser; idle-high so reset does not look like a start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= rx;
      rx_s  <= sync1;
    end
  end

  // Receiver state, bit-timing counter, bit index and shift register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      idx   <= idx_d;
      shift <= shift_d;
    end
  end

  // Next-state logic: the counter runs freely and is cleared whenever a state is (re)entered.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt + CNT_ONE;
    idx_d     = idx;
    shift_d   = shift;
    byte_done = 1'b0;
    frame_bad = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt == HALF_M1) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d = DATA;
            idx_d   = '0;
          end else begin
            state_d = IDLE;   // line went back high: treat as a glitch
          end
        end
      end
      DATA: begin
        if (cnt == FULL_M1) begin
          cnt_d        = '0;
          shift_d[idx] = rx_s;
          if (idx == 3'd7) begin
            state_d = STOP;
          end else begin
            idx_d = idx + 3'd1;
          end
        end
      end
      STOP: begin
        if (cnt == FULL_M1) begin
          cnt_d = '0;
          if (rx_s) begin
            byte_done = 1'b1;
            state_d   = IDLE;
          end else begin
            frame_bad = 1'b1;
            state_d   = BREAK;
          end
        end
      end
      BREAK: begin
        // Wait for the line to return high so a held-low line cannot retrigger starts.
        if (rx_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output buffer: load on completion if empty or being consumed in the same cycle, else drop and flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data        <= 8'h00;
      valid       <= 1'b0;
      framing_err <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      framing_err <= frame_bad;
      overrun     <= 1'b0;
      if (byte_done) begin
        if (!valid || ready) begin
          data  <= shift;
          valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed scenarios plus randomized frames checked against a byte-queue model.
module tb_uart_rx;

  localparam int CPB      = 8;
  localparam int H        = CPB / 2;
  // Frame-relative cycle (0 = first cycle the start bit is on the pin) on which the stop bit is sampled.
  localparam int DONE_OFS = 2 + H + 9 * CPB;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       rx    = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] data;
  logic       valid, busy, framing_err, overrun;

  int n_cmp = 0;
  int n_err = 0;

  // Observations gathered away from the active edge.
  int         valid_cycles = 0;
  int         fe_cnt       = 0;
  int         ov_cnt       = 0;
  int         both_cnt     = 0;
  logic [7:0] acc_q[$];

  uart_rx #(.CLKS_PER_BIT(CPB), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .rx(rx), .data(data), .valid(valid), .ready(ready),
    .busy(busy), .framing_err(framing_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset) begin
      if (valid) valid_cycles++;
      if (valid && ready) acc_q.push_back(data);
      fe_cnt += int'(framing_err);
      ov_cnt += int'(overrun);
      if (framing_err && overrun) both_cnt++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) tick();
  endtask

  // Drive one full frame; ready is base_rdy except on frame cycle rdy_pos. Line is left at the stop value.
  task automatic send(input logic [7:0] b, input logic stop_bit, input logic base_rdy, input int rdy_pos);
    for (int i = 0; i < 10 * CPB; i++) begin
      int bi;
      bi = i / CPB;
      if (bi == 0)      rx = 1'b0;
      else if (bi == 9) rx = stop_bit;
      else              rx = b[bi-1];
      ready = (i == rdy_pos) ? 1'b1 : base_rdy;
      tick();
    end
    ready = base_rdy;
  endtask

  function automatic logic [7:0] last_acc();
    return (acc_q.size() > 0) ? acc_q[acc_q.size()-1] : 8'hXX;
  endfunction

  int         v0, f0, o0, a0, exp_fe;
  logic [7:0] exp_q[$];
  logic [7:0] c3;
  logic [7:0] rb;
  logic       bad;

  initial begin
    // Reset values
    repeat (3) tick();
    check("rst_data", data, 8'h00);
    check("rst_valid", valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_fe", framing_err, 1'b0);
    check("rst_ov", overrun, 1'b0);
    reset = 1'b0;
    idle(5);

    // 1: single byte consumed immediately
    ready = 1'b1;
    v0 = valid_cycles; f0 = fe_cnt; o0 = ov_cnt; a0 = acc_q.size();
    send(8'hA5, 1'b1, 1'b1, -1);
    idle(10);
    check("t1_count", acc_q.size() - a0, 1);
    check("t1_data", last_acc(), 8'hA5);
    check("t1_vcyc", valid_cycles - v0, 1);
    check("t1_fe", fe_cnt - f0, 0);
    check("t1_ov", ov_cnt - o0, 0);
    check("t1_busy", busy, 1'b0);

    // 2: back-to-back with consumer stalled -> second byte overruns
    ready = 1'b0;
    o0 = ov_cnt; a0 = acc_q.size();
    send(8'h48, 1'b1, 1'b0, -1);
    send(8'h0D, 1'b1, 1'b0, -1);
    idle(5);
    check("t2_valid", valid, 1'b1);
    check("t2_data", data, 8'h48);
    check("t2_ov", ov_cnt - o0, 1);
    check("t2_noacc", acc_q.size() - a0, 0);
    ready = 1'b1; tick(); ready = 1'b0; idle(2);
    check("t2_drain", last_acc(), 8'h48);
    check("t2_valid_clr", valid, 1'b0);

    // 3: consume on the exact completion cycle of the next byte
    send(8'h01, 1'b1, 1'b0, -1);
    idle(3);
    check("t3_pend", data, 8'h01);
    o0 = ov_cnt;
    send(8'hFF, 1'b1, 1'b0, DONE_OFS);
    idle(3);
    check("t3_data", data, 8'hFF);
    check("t3_valid", valid, 1'b1);
    check("t3_ov", ov_cnt - o0, 0);
    check("t3_acc01", last_acc(), 8'h01);
    ready = 1'b1; tick(); ready = 1'b0; idle(2);
    check("t3_accFF", last_acc(), 8'hFF);

    // 4: bad stop bit then held-low line
    ready = 1'b1;
    v0 = valid_cycles; f0 = fe_cnt; a0 = acc_q.size();
    send(8'h55, 1'b0, 1'b1, -1);
    repeat (40) tick();
    check("t4_fe", fe_cnt - f0, 1);
    check("t4_valid", valid, 1'b0);
    check("t4_vcyc", valid_cycles - v0, 0);
    check("t4_busy_brk", busy, 1'b1);
    idle(5);
    check("t4_busy_idle", busy, 1'b0);
    send(8'h3C, 1'b1, 1'b1, -1);
    idle(5);
    check("t4_count", acc_q.size() - a0, 1);
    check("t4_data", last_acc(), 8'h3C);
    check("t4_fe_once", fe_cnt - f0, 1);

    // 5: short low glitch on idle line
    v0 = valid_cycles; f0 = fe_cnt; o0 = ov_cnt;
    idle(3);
    rx = 1'b0; tick(); tick();
    rx = 1'b1; tick();
    check("t5_busy_start", busy, 1'b1);
    repeat (15) tick();
    check("t5_busy", busy, 1'b0);
    check("t5_vcyc", valid_cycles - v0, 0);
    check("t5_flags", (fe_cnt - f0) + (ov_cnt - o0), 0);

    // 6: reset in the middle of a frame
    c3 = 8'hC3;
    for (int i = 0; i < 4 * CPB; i++) begin
      int bi;
      bi = i / CPB;
      rx = (bi == 0) ? 1'b0 : c3[bi-1];
      tick();
    end
    check("t6_busy_mid", busy, 1'b1);
    #1 reset = 1'b1;
    #1;
    check("t6_rst_data", data, 8'h00);
    check("t6_rst_valid", valid, 1'b0);
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_flags", {framing_err, overrun}, 2'b00);
    rx = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    idle(5);
    a0 = acc_q.size();
    send(8'h7E, 1'b1, 1'b1, -1);
    idle(5);
    check("t6_count", acc_q.size() - a0, 1);
    check("t6_data", last_acc(), 8'h7E);

    // Randomized frames: good bytes must arrive in order, bad stop bits only raise framing_err
    ready = 1'b1;
    idle(5);
    a0 = acc_q.size(); f0 = fe_cnt; o0 = ov_cnt; exp_fe = 0;
    for (int n = 0; n < 24; n++) begin
      rb  = 8'($urandom_range(0, 255));
      bad = ($urandom_range(0, 5) == 0);
      send(rb, !bad, 1'b1, -1);
      if (bad) begin
        exp_fe++;
        idle($urandom_range(3, 6));
      end else begin
        exp_q.push_back(rb);
        idle($urandom_range(0, 4));
      end
    end
    idle(10);
    check("rand_count", acc_q.size() - a0, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      check("rand_byte", (a0 + i < acc_q.size()) ? {24'h0, acc_q[a0+i]} : 32'hDEAD, {24'h0, exp_q[i]});
    end
    check("rand_fe", fe_cnt - f0, exp_fe);
    check("rand_ov", ov_cnt - o0, 0);
    check("flags_exclusive", both_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
